// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address and IF/ID pipeline register.
// Redirects (branch, jr, j) flush IF/ID and take priority over a load-use stall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    input  logic        Stall,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] JrTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] Instr_ID,
    output logic [31:0] PCPlus4_ID,
    output logic        Valid_ID,
    output logic [5:0]  OpCode,
    output logic [4:0]  Rt
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic        redirect;

    always_comb begin
        pc_plus4    = pc_q + 32'd4;
        jump_target = {pcp4_q[31:28], instr_q[25:0], 2'b00};
        // Redirect requests only mean something when IF/ID holds a real instruction.
        redirect    = (BranchTaken | JumpReg | Jump) & valid_q;

        pc_d = pc_plus4;
        if (valid_q && BranchTaken) begin
            pc_d = {BranchTarget[31:2], 2'b00};
        end else if (valid_q && JumpReg) begin
            pc_d = {JrTarget[31:2], 2'b00};
        end else if (valid_q && Jump) begin
            pc_d = jump_target;
        end else if (Stall) begin
            pc_d = pc_q;
        end

        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (redirect) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!Stall) begin
            instr_d = IMemData;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcp4_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign IMemAddr   = pc_q;
    assign Instr_ID   = instr_q;
    assign PCPlus4_ID = pcp4_q;
    assign Valid_ID   = valid_q;
    assign OpCode     = instr_q[31:26];
    assign Rt         = instr_q[20:16];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: a table of per-edge inputs and expected IF state,
// followed by a hand-written asynchronous-reset-during-stall sequence.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] IMemAddr;
    logic [31:0] IMemData;
    logic        Stall, Jump, JumpReg, BranchTaken;
    logic [31:0] JrTarget, BranchTarget;
    logic [31:0] Instr_ID, PCPlus4_ID;
    logic        Valid_ID;
    logic [5:0]  OpCode;
    logic [4:0]  Rt;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .IMemAddr     (IMemAddr),
        .IMemData     (IMemData),
        .Stall        (Stall),
        .Jump         (Jump),
        .JumpReg      (JumpReg),
        .JrTarget     (JrTarget),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Instr_ID     (Instr_ID),
        .PCPlus4_ID   (PCPlus4_ID),
        .Valid_ID     (Valid_ID),
        .OpCode       (OpCode),
        .Rt           (Rt)
    );

    always #5 Clk = ~Clk;

    // IMem[i] = i (word index), except one slot holding "j 0x100".
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h1000_0004) return 32'h0800_0040;
        return a >> 2;
    endfunction

    always_comb IMemData = imem(IMemAddr);

    typedef struct {
        logic        stall;
        logic        jump;
        logic        jumpreg;
        logic [31:0] jrt;
        logic        br;
        logic [31:0] brt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] pcp4, input logic valid);
        logic [31:0] ei;
        ei = instr;
        check({tag, " IMemAddr"}, IMemAddr, pc);
        check({tag, " Instr_ID"}, Instr_ID, instr);
        check({tag, " PCPlus4_ID"}, PCPlus4_ID, pcp4);
        check({tag, " Valid_ID"}, {31'b0, Valid_ID}, {31'b0, valid});
        check({tag, " OpCode"}, {26'b0, OpCode}, {26'b0, ei[31:26]});
        check({tag, " Rt"}, {27'b0, Rt}, {27'b0, ei[20:16]});
    endtask

    task automatic drive(input logic s, input logic j, input logic jr, input logic [31:0] jrt,
                         input logic b, input logic [31:0] bt);
        Stall = s; Jump = j; JumpReg = jr; JrTarget = jrt; BranchTaken = b; BranchTarget = bt;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        //         stall jump jr  jrt            br   brt            pc             instr          pcp4           valid
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0008, 32'h0000_0001, 32'h0000_0008, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_000C, 32'h0000_0002, 32'h0000_000C, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0010, 32'h0000_0003, 32'h0000_0010, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0010, 32'h0000_0003, 32'h0000_0010, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0010, 32'h0000_0003, 32'h0000_0010, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0010, 32'h0000_0003, 32'h0000_0010, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0014, 32'h0000_0004, 32'h0000_0014, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h1000_0004, 32'h1000_0004, 32'h0000_0000, 32'h0000_0014, 1'b0};
        // Branch request while IF/ID is a bubble must be ignored.
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0040, 32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       32'h1000_0100, 32'h0000_0000, 32'h1000_0008, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h1000_0104, 32'h0400_0040, 32'h1000_0104, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h2000_0003, 1'b0, 32'h0,     32'h2000_0000, 32'h0000_0000, 32'h1000_0104, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h2000_0004, 32'h0800_0000, 32'h2000_0004, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0000, 32'h2000_0004, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0040, 32'h0000_0000, 32'h2000_0004, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0044, 32'h0000_0010, 32'h0000_0044, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,     32'h0000_0200, 32'h0000_0000, 32'h0000_0044, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0204, 32'h0000_0080, 32'h0000_0204, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0204, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0000_0000, 32'h3FFF_FFFF, 32'h0000_0000, 1'b1};

        Reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].stall, vecs[i].jump, vecs[i].jumpreg, vecs[i].jrt,
                  vecs[i].br, vecs[i].brt);
            step();
            check_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pcp4,
                        vecs[i].valid);
        end

        // Asynchronous reset asserted mid-cycle while stalled.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        step();
        check_state("pre_rst", 32'h0000_0008, 32'h0000_0001, 32'h0000_0008, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        check_state("stall_hold", 32'h0000_0008, 32'h0000_0001, 32'h0000_0008, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        check_state("rst_held", 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        check_state("post_rst", 32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
